muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS HI/LO unit, i.e. MULT, MULTU, DIV and DIVU. It sits beside the execute-stage ALU. It accepts an operation from E, holds the pipeline with `stall_req` while an iterative divider or a fixed-latency multiplier runs, then presents a 64-bit result for the HI/LO write. It owns the FSM, the cycle counting, sign handling and flush/reset cancellation; the bit-serial divide datapath is a sub-module.

---
 rtl/muldiv_ctrl_pkg.sv | 56 +++++
 rtl/muldiv_ctrl_if.sv | 30 +++
 rtl/muldiv_ctrl_div_radix2.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 169 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   md_op_e     : decoder op encoding as carried on the op bus (MULT/MULTU/DIV/DIVU)
//   md_state_e  : sequencer FSM states
//   md_div_t    : remainder/quotient pair of the restoring divider
//   md_div_step : one restoring-division iteration (one quotient bit)
package muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

   localparam int         MD_DIV_ITERS    = 32;
   localparam logic [5:0] MD_DIV_CNT_LOAD = 6'(MD_DIV_ITERS - 1);

   typedef struct packed {
      logic [31:0] rem;
      logic [31:0] quo;
   } md_div_t;

   // op[1] selects the divide family, op[0] selects unsigned.
   function automatic logic md_is_div(input md_op_e op);
      return op[1];
   endfunction

   function automatic logic md_is_signed(input md_op_e op);
      return !op[0];
   endfunction

   // Shift the next dividend bit into the partial remainder and subtract the
   // divisor when it fits. The partial remainder is always below the divisor,
   // so the 33-bit trial value minus the divisor always fits back in 32 bits.
   function automatic md_div_t md_div_step(input md_div_t cur, input logic [31:0] dvs);
      logic [32:0] trial;
      md_div_t     nxt;
      trial = {cur.rem, cur.quo[31]};
      if (trial >= {1'b0, dvs}) begin
         nxt.rem = trial[31:0] - dvs;
         nxt.quo = {cur.quo[30:0], 1'b1};
      end else begin
         nxt.rem = trial[31:0];
         nxt.quo = {cur.quo[30:0], 1'b0};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: execute-stage <-> HI/LO sequencer handshake.
//   start/op/src_a/src_b : instruction offered by E (held while stalled)
//   flush                : cancel the E-stage instruction
//   stall_req            : freeze F/D/E
//   done/result_hi/lo    : one-cycle HI/LO write strobe with its data
// master = pipeline side, slave = sequencer side.
interface muldiv_ctrl_if;
   import muldiv_ctrl_pkg::*;

   logic        start;
   md_op_e      op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall_req;
   logic        done;
   logic [31:0] result_hi;
   logic [31:0] result_lo;

   modport master (
      output start, op, src_a, src_b, flush,
      input  stall_req, done, result_hi, result_lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush,
      output stall_req, done, result_hi, result_lo
   );

endinterface

// File: rtl/muldiv_ctrl_div_radix2.sv
// div_radix2: bit-serial restoring divider for unsigned 32-bit operands.
//   clk, resetn         : clock, synchronous active-low reset
//   load                : capture dividend/divisor and perform the first iteration
//   en                  : perform one further iteration
//   dividend, divisor   : unsigned operands, sampled with load
//   quotient, remainder : final after load plus 31 enabled cycles (32 iterations)
module div_radix2
   import muldiv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   md_div_t     st_q;
   md_div_t     seed;
   logic [31:0] dvs_q;

   assign seed = {32'd0, dividend};

   // The load cycle already retires the first quotient bit so that the last
   // bit is ready one cycle earlier and the caller can register its sign
   // fixup on the final DIV cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         st_q  <= '0;
         dvs_q <= '0;
      end else if (load) begin
         st_q  <= md_div_step(seed, divisor);
         dvs_q <= divisor;
      end else if (en) begin
         st_q  <= md_div_step(st_q, dvs_q);
      end
   end

   assign quotient  = st_q.quo;
   assign remainder = st_q.rem;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle sequencer for MULT/MULTU/DIV/DIVU writing HI/LO.
//   MUL_LAT : cycles spent in MUL (depth of the product register chain), >= 1
//   clk     : clock, rising edge
//   resetn  : synchronous active-low reset
//   bus     : muldiv_ctrl_if.slave (start/op/src_a/src_b/flush in,
//             stall_req/done/result_hi/result_lo out)
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic         clk,
   input  logic         resetn,
   muldiv_ctrl_if.slave bus
);

   md_state_e   state_q, state_d;
   logic [5:0]  cnt_q;
   logic        cnt_last;
   logic        accept, div_zero, div_load, div_en;
   logic        stall_c, done_c;
   logic        sgn_q, sgn_in;
   logic [31:0] a_q, b_q, hi_q, lo_q;
   logic [31:0] mag_a, mag_b, quo, rem;
   logic        q_neg, r_neg;
   logic [63:0] mul_a, mul_b, prod, prod_final;

   assign cnt_last = (cnt_q == 6'd0);
   assign div_zero = (bus.src_b == 32'd0);
   assign sgn_in   = md_is_signed(bus.op);

   // Next-state and handshake outputs. Flush overrides everything, and while
   // reset is held no stall or done may reach the pipeline.
   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      done_c  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.flush) begin
               accept  = 1'b1;
               stall_c = 1'b1;
               if (!md_is_div(bus.op))
                  state_d = ST_MUL;
               else if (div_zero)
                  state_d = ST_DONE;
               else
                  state_d = ST_DIV;
            end
         end
         ST_MUL, ST_DIV: begin
            stall_c = !bus.flush;
            if (cnt_last)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            done_c  = !bus.flush;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush)
         state_d = ST_IDLE;
      if (!resetn) begin
         stall_c = 1'b0;
         done_c  = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Cycle counter: loaded on acceptance, counts down to the terminal zero
   // and holds there, so it never wraps.
   always_ff @(posedge clk) begin
      if (!resetn)
         cnt_q <= 6'd0;
      else if (accept)
         cnt_q <= md_is_div(bus.op) ? MD_DIV_CNT_LOAD : 6'(MUL_LAT - 1);
      else if ((state_q == ST_MUL || state_q == ST_DIV) && !cnt_last)
         cnt_q <= cnt_q - 6'd1;
   end

   // Operand capture; the signs of the raw operands drive the divide fixup.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sgn_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
      end else if (accept) begin
         sgn_q <= sgn_in;
         a_q   <= bus.src_a;
         b_q   <= bus.src_b;
      end
   end

   // Multiplier: extending both operands to 64 bits (sign or zero) and keeping
   // the low 64 bits of the product equals the exact 33x33-bit signed product.
   assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
   assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = mul_a * mul_b;

   // The result register is the last stage of the product chain, so only
   // MUL_LAT-1 intermediate stages live here.
   generate
      if (MUL_LAT == 1) begin : g_mul_direct
         assign prod_final = prod;
      end else begin : g_mul_pipe
         logic [63:0] pipe [MUL_LAT-1];
         always_ff @(posedge clk) begin
            pipe[0] <= prod;
            for (int i = 1; i < MUL_LAT - 1; i++)
               pipe[i] <= pipe[i-1];
         end
         assign prod_final = pipe[MUL_LAT-2];
      end
   endgenerate

   // Divider is fed magnitudes taken from the raw operands at acceptance.
   assign mag_a    = (sgn_in && bus.src_a[31]) ? -bus.src_a : bus.src_a;
   assign mag_b    = (sgn_in && bus.src_b[31]) ? -bus.src_b : bus.src_b;
   assign div_load = accept && md_is_div(bus.op) && !div_zero;
   assign div_en   = (state_q == ST_DIV) && !cnt_last;

   div_radix2 u_div (
      .clk       (clk),
      .resetn    (resetn),
      .load      (div_load),
      .en        (div_en),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem)
   );

   assign q_neg = sgn_q & (a_q[31] ^ b_q[31]);
   assign r_neg = sgn_q & a_q[31];

   // HI/LO result registers, written on the edge that enters DONE and held
   // otherwise. A flushed operation never updates them. MIN_INT / -1 needs no
   // special case: the unsigned quotient 0x8000_0000 is simply left un-negated.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (div_zero && accept && md_is_div(bus.op)) begin
         hi_q <= bus.src_a;
         lo_q <= 32'hFFFF_FFFF;
      end else if (!bus.flush && state_q == ST_MUL && cnt_last) begin
         hi_q <= prod_final[63:32];
         lo_q <= prod_final[31:0];
      end else if (!bus.flush && state_q == ST_DIV && cnt_last) begin
         hi_q <= r_neg ? -rem : rem;
         lo_q <= q_neg ? -quo : quo;
      end
   end

   assign bus.stall_req = stall_c;
   assign bus.done      = done_c;
   assign bus.result_hi = hi_q;
   assign bus.result_lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed, scoreboard-checked bench for muldiv_ctrl.
// Stimulus pushes the hand-computed HI/LO and the edge count at which done
// must appear; an independent monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          doneEdge;
   } exp_t;

   logic clk;
   logic resetn;
   int   edgeCount  = 0;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t expQ[$];

   muldiv_ctrl_if bus ();

   muldiv_ctrl #(.MUL_LAT(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Free-running clock and an edge counter used to time done pulses.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation,
   // including the edge it was due on; a done with nothing pending is an error.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_done", 64'(bus.done), 64'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput({e.name, "_hi"}, 64'(bus.result_hi), 64'(e.hi));
            checkOutput({e.name, "_lo"}, 64'(bus.result_lo), 64'(e.lo));
            checkOutput({e.name, "_cycle"}, 64'(edgeCount), 64'(e.doneEdge));
         end
      end
   end

   // Issue one instruction as the pipeline would: hold start while stalled,
   // count stall cycles up to done, then release start once done has passed.
   // Called just after a falling edge; that cycle is cycle 0.
   task automatic applyStimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                input string name, input logic [31:0] expHi,
                                input logic [31:0] expLo, input int doneCyc);
      exp_t e;
      int   stalls;
      bit   seen;
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      e.name     = name;
      e.hi       = expHi;
      e.lo       = expLo;
      e.doneEdge = edgeCount + doneCyc;
      expQ.push_back(e);
      stalls = 0;
      seen   = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         #1;
         if (bus.stall_req) stalls++;
         if (bus.done) seen = 1'b1;
         @(negedge clk);
      end
      bus.start = 1'b0;
      #1;
      checkOutput({name, "_seen"}, 64'(seen), 64'd1);
      checkOutput({name, "_stalls"}, 64'(stalls), 64'(doneCyc));
      checkOutput({name, "_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      resetn    = 1'b0;
      bus.start = 1'b1;
      bus.op    = MD_MULT;
      bus.src_a = 32'd3;
      bus.src_b = 32'd5;
      bus.flush = 1'b0;

      // Reset holds stall and done low even with start asserted.
      repeat (3) @(negedge clk);
      checkOutput("rst_stall", 64'(bus.stall_req), 64'd0);
      checkOutput("rst_done", 64'(bus.done), 64'd0);
      checkOutput("rst_hi", 64'(bus.result_hi), 64'd0);
      checkOutput("rst_lo", 64'(bus.result_lo), 64'd0);
      bus.start = 1'b0;
      resetn    = 1'b1;
      @(negedge clk);

      // Divides, multiplies and divide-by-zero, issued back to back.
      applyStimulus(MD_DIVU, 32'd100,        32'd7,          "divu_100_7",   32'd2,          32'd14,         33);
      applyStimulus(MD_DIV,  32'hFFFF_FFF9,  32'd2,          "div_m7_2",     32'hFFFF_FFFF,  32'hFFFF_FFFD,  33);
      applyStimulus(MD_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  "div_min_m1",   32'd0,          32'h8000_0000,  33);
      applyStimulus(MD_DIV,  32'd7,          32'hFFFF_FFFE,  "div_7_m2",     32'd1,          32'hFFFF_FFFD,  33);
      applyStimulus(MD_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  "div_m100_m7",  32'hFFFF_FFFE,  32'd14,         33);
      applyStimulus(MD_DIVU, 32'hFFFF_FFFF,  32'h10,         "divu_max_16",  32'hF,          32'h0FFF_FFFF,  33);
      applyStimulus(MD_MULT, 32'hFFFF_FFFF,  32'd2,          "mult_m1_2",    32'hFFFF_FFFF,  32'hFFFF_FFFE,  3);
      applyStimulus(MD_MULTU,32'hFFFF_FFFF,  32'd2,          "multu_max_2",  32'd1,          32'hFFFF_FFFE,  3);
      applyStimulus(MD_MULT, 32'hFFFF_FFFD,  32'd5,          "mult_m3_5",    32'hFFFF_FFFF,  32'hFFFF_FFF1,  3);
      applyStimulus(MD_MULT, 32'h8000_0000,  32'h8000_0000,  "mult_min_min", 32'h4000_0000,  32'd0,          3);
      applyStimulus(MD_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mult_m1_m1",   32'd0,          32'd1,          3);
      applyStimulus(MD_MULTU,32'hFFFF_FFFF,  32'hFFFF_FFFF,  "multu_max_max",32'hFFFF_FFFE,  32'd1,          3);
      applyStimulus(MD_DIVU, 32'h1234,       32'd0,          "divu_by0",     32'h1234,       32'hFFFF_FFFF,  1);
      applyStimulus(MD_DIV,  32'hFFFF_FF00,  32'd0,          "div_by0_neg",  32'hFFFF_FF00,  32'hFFFF_FFFF,  1);

      // Flush in cycle 10 of a divide: stall drops at once, no done follows,
      // and a multiply started in cycle 11 completes in cycle 14.
      bus.start = 1'b1;
      bus.op    = MD_DIVU;
      bus.src_a = 32'd100;
      bus.src_b = 32'd7;
      repeat (10) @(negedge clk);
      checkOutput("div_stall_c10", 64'(bus.stall_req), 64'd1);
      bus.flush = 1'b1;
      #1;
      checkOutput("flush_stall", 64'(bus.stall_req), 64'd0);
      @(negedge clk);
      bus.flush = 1'b0;
      applyStimulus(MD_MULTU, 32'd3, 32'd5, "multu_after_flush", 32'd0, 32'd15, 3);

      // Reset in cycle 20 of a divide clears results and returns to IDLE.
      bus.start = 1'b1;
      bus.op    = MD_DIV;
      bus.src_a = 32'hFFFF_FFF9;
      bus.src_b = 32'd2;
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("rst_mid_stall", 64'(bus.stall_req), 64'd0);
      @(negedge clk);
      checkOutput("rst_mid_hi", 64'(bus.result_hi), 64'd0);
      checkOutput("rst_mid_lo", 64'(bus.result_lo), 64'd0);
      checkOutput("rst_mid_done", 64'(bus.done), 64'd0);
      bus.start = 1'b0;
      resetn    = 1'b1;
      @(negedge clk);

      // start and flush together in IDLE: nothing may be accepted.
      bus.start = 1'b1;
      bus.op    = MD_MULTU;
      bus.src_a = 32'd6;
      bus.src_b = 32'd7;
      bus.flush = 1'b1;
      #1;
      checkOutput("start_flush_stall", 64'(bus.stall_req), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      #1;
      checkOutput("start_flush_idle", 64'(bus.stall_req), 64'd0);
      repeat (4) @(negedge clk);
      checkOutput("start_flush_lo", 64'(bus.result_lo), 64'd0);

      // The unit still works after reset.
      applyStimulus(MD_MULTU, 32'd6, 32'd7, "multu_after_rst", 32'd0, 32'd42, 3);

      repeat (3) @(negedge clk);
      checkOutput("pending_results", 64'(expQ.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
